// File: rtl/qpix_srx_pkg.sv
// Shared definitions for the QPix serial readback receiver.
// SRX_HALF_PERIOD is also the sclk half-period used by the serial transmitters,
// so the read and write directions run at the same shift rate.
package qpix_srx_pkg;

  localparam int SRX_WIDTH       = 32;
  localparam int SRX_HALF_PERIOD = 4;
  localparam int SRX_CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } srx_state_t;

  // Bit counter must hold the value WIDTH itself (count after the last rise).
  function automatic int srx_bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/qpix_serial_rx_if.sv
// Register-file side of the serial readback receiver.
// master = reg_rw / register file, slave = receiver.
interface qpix_serial_rx_if
  import qpix_srx_pkg::*;
#(
  parameter int WIDTH = SRX_WIDTH,
  parameter int CNT_W = SRX_CNT_W
) ();

  logic             start;
  logic [WIDTH-1:0] exp_data;
  logic             busy;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [CNT_W-1:0] rx_count;
  logic             mismatch;

  modport master (
    output start, exp_data,
    input  busy, rx_data, rx_valid, rx_count, mismatch
  );

  modport slave (
    input  start, exp_data,
    output busy, rx_data, rx_valid, rx_count, mismatch
  );

endinterface

// File: rtl/srx_clk_div.sv
// sclk phase generator: HALF_PERIOD clk cycles per phase, low phase first.
// rise/fall are strobes on the cycle whose clock edge flips the phase,
// so the registered phase output changes one cycle after the strobe.
module srx_clk_div
  import qpix_srx_pkg::*;
#(
  parameter int HALF_PERIOD = SRX_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [DIV_W-1:0] cnt;
  logic             term;

  assign term = (cnt == DIV_W'(HALF_PERIOD - 1));
  assign rise = en & ~clr & term & ~phase;
  assign fall = en & ~clr & term & phase;

  // Phase counter; clear parks the divider at the start of a low phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (term) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/qpix_serial_rx.sv
// QPix serial readback receiver: drives a gated sclk toward the ASIC and
// deserializes SDO (MSB first) into a WIDTH-bit word for the register file.
// Optional feature macro: QPIX_SRX_COMPARE_EN (latch exp_data at the start
// edge and flag a sticky mismatch against the received word).
module qpix_serial_rx
  import qpix_srx_pkg::*;
#(
  parameter int WIDTH       = SRX_WIDTH,
  parameter int HALF_PERIOD = SRX_HALF_PERIOD,
  parameter int CNT_W       = SRX_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sdo,
  output logic                   sclk,
  qpix_serial_rx_if.slave        bus
);

  localparam int BC_W = srx_bit_cnt_w(WIDTH);

  srx_state_t       state;
  srx_state_t       state_nxt;
  logic             sdo_m;
  logic             sdo_s;
  logic             start_q;
  logic             start_qq;
  logic             start_edge;
  logic             accept;
  logic             frame_end;
  logic [BC_W-1:0]  bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] rx_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_en;
  logic             div_clr;
  logic             rise;
  logic             fall;
  logic             busy;
  logic             rx_valid;

  // sdo is asynchronous to clk; start comes from reg_rw and only needs an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdo_m    <= 1'b0;
      sdo_s    <= 1'b0;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
    end else begin
      sdo_m    <= sdo;
      sdo_s    <= sdo_m;
      start_q  <= bus.start;
      start_qq <= start_q;
    end
  end

  assign start_edge = start_q & ~start_qq;
  // Only edges seen in IDLE start a frame; edges while busy are dropped.
  assign accept     = (state == IDLE) & start_edge;
  // End of the high phase of the last bit: sclk returns low as DONE is entered.
  assign frame_end  = fall & (bit_cnt == BC_W'(WIDTH));

  srx_clk_div #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .en    (div_en),
    .clr   (div_clr),
    .phase (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = SHIFT;
      SHIFT:   if (frame_end)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and divider control.
  always_comb begin
    busy     = 1'b0;
    rx_valid = 1'b0;
    div_en   = 1'b0;
    div_clr  = 1'b1;
    case (state)
      SHIFT: begin
        busy    = 1'b1;
        div_en  = 1'b1;
        div_clr = 1'b0;
      end
      DONE: begin
        busy     = 1'b1;
        rx_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift register samples synchronized sdo on each sclk rise, MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (accept) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (rise) begin
      bit_cnt <= bit_cnt + BC_W'(1);
      shreg   <= {shreg[WIDTH-2:0], sdo_s};
    end
  end

  // Result registers load on entry to DONE so rx_data and rx_count are
  // already current while rx_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q <= '0;
      cnt_q     <= '0;
    end else if (frame_end) begin
      rx_data_q <= shreg;
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

`ifdef QPIX_SRX_COMPARE_EN
  logic [WIDTH-1:0] exp_q;
  logic             mismatch_q;

  // Expected word is captured with the accepted start; the flag is sticky
  // until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else if (accept) begin
      exp_q      <= bus.exp_data;
      mismatch_q <= 1'b0;
    end else if (frame_end) begin
      mismatch_q <= mismatch_q | (shreg != exp_q);
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  logic unused_exp;
  assign unused_exp   = ^bus.exp_data;
  assign bus.mismatch = 1'b0;
`endif

  assign bus.busy     = busy;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_count = cnt_q;

endmodule

// File: tb/tb_qpix_serial_rx.sv
// Directed bench for qpix_serial_rx with a behavioural ASIC that launches
// SDO (MSB first) on sclk falling edges.
module tb_qpix_serial_rx;
  import qpix_srx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sdo;
  logic sclk;

  qpix_serial_rx_if #(.WIDTH(32), .CNT_W(16)) bus ();

  qpix_serial_rx #(
    .WIDTH       (32),
    .HALF_PERIOD (4),
    .CNT_W       (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sdo  (sdo),
    .sclk (sclk),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int sclk_rises = 0;
  int sclk_falls = 0;
  int valid_cnt = 0;

  always @(posedge sclk) sclk_rises <= sclk_rises + 1;
  always @(negedge sclk) sclk_falls <= sclk_falls + 1;
  always @(negedge clk) if (bus.rx_valid) valid_cnt <= valid_cnt + 1;

  // ASIC model: bit 31 is on the wire before the first rise, next bit after
  // each fall. sdo_ovr forces the line for idle-noise tests.
  logic [31:0] asic_word;
  int          asic_base;
  int          idx;
  logic        sdo_ovr;
  logic        sdo_ovr_val;

  always_comb begin
    idx = sclk_falls - asic_base;
    sdo = 1'b0;
    if (sdo_ovr) sdo = sdo_ovr_val;
    else if (idx >= 0 && idx < 32) sdo = asic_word[31-idx];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full frame: start edge, ASIC returns word. Start is left high.
  task automatic run_frame(input logic [31:0] word, input bit repulse);
    int c;
    int got_at;
    int r0;
    int v0;
    asic_word = word;
    sdo_ovr   = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    asic_base = sclk_falls;
    r0        = sclk_rises;
    v0        = valid_cnt;
    bus.start = 1'b1;
    got_at    = -1;
    c         = 0;
    while (c < 400 && got_at < 0) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 1) chk("busy_at_edge_cycle", bus.busy, 0);
      if (c == 2) chk("busy_after_edge", bus.busy, 1);
      if (repulse && c == 60) bus.start = 1'b0;
      if (repulse && c == 64) bus.start = 1'b1;
      if (bus.rx_valid) begin
        got_at = c;
        chk("rx_data", bus.rx_data, word);
      end
    end
    chk("valid_cycle", got_at, 258);
    @(posedge clk);
    #1;
    chk("busy_drop", bus.busy, 0);
    chk("valid_one_cycle", bus.rx_valid, 0);
    chk("sclk_rises", sclk_rises - r0, 32);
    repeat (repulse ? 300 : 10) @(posedge clk);
    #1;
    chk("frames_per_start", valid_cnt - v0, 1);
  endtask

  initial begin
    int c;
    int r0;
    int v0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.exp_data = 32'h0;
    sdo_ovr     = 1'b0;
    sdo_ovr_val = 1'b0;
    asic_word   = 32'h0;
    asic_base   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_count", bus.rx_count, 0);
    chk("rst_mismatch", bus.mismatch, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, then a frame with an ignored mid-frame re-pulse.
    run_frame(32'h12345678, 1'b0);
    chk("count_after_1", bus.rx_count, 1);
    run_frame(32'hA0A0A0AF, 1'b1);
    chk("count_after_2", bus.rx_count, 2);
    chk("data_after_2", bus.rx_data, 32'hA0A0A0AF);

    // Reset after 10 sclk rises.
    asic_word = 32'hDEADBEEF;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    asic_base = sclk_falls;
    r0        = sclk_rises;
    bus.start = 1'b1;
    c = 0;
    while (c < 200 && (sclk_rises - r0) < 10) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("rises_before_rst", sclk_rises - r0, 10);
    chk("sclk_high_before_rst", sclk, 1);
    rst = 1'b1;
    #1;
    chk("midrst_sclk", sclk, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_rx_data", bus.rx_data, 0);
    chk("midrst_rx_count", bus.rx_count, 0);
    chk("midrst_rx_valid", bus.rx_valid, 0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(32'h3C5AA5C3, 1'b0);
    chk("count_after_rst_frame", bus.rx_count, 1);

    // Start held high for 1000 cycles gives one frame only.
    asic_word = 32'h5A5A3C3C;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    asic_base = sclk_falls;
    v0        = valid_cnt;
    bus.start = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("held_frames", valid_cnt - v0, 1);
    chk("held_rx_data", bus.rx_data, 32'h5A5A3C3C);
    chk("held_rx_count", bus.rx_count, 2);

    // sdo noise in IDLE.
    sdo_ovr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      sdo_ovr_val = ~sdo_ovr_val;
    end
    sdo_ovr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_sdo_rx_data", bus.rx_data, 32'h5A5A3C3C);
    chk("idle_sdo_rx_count", bus.rx_count, 2);
    chk("idle_sdo_busy", bus.busy, 0);

    // Compare against expected word.
    bus.exp_data = 32'h12345678;
    run_frame(32'h12345679, 1'b0);
`ifdef QPIX_SRX_COMPARE_EN
    chk("mismatch_set", bus.mismatch, 1);
`else
    chk("mismatch_tied", bus.mismatch, 0);
`endif
    run_frame(32'h12345678, 1'b0);
    chk("mismatch_clear", bus.mismatch, 0);
    chk("count_after_cmp", bus.rx_count, 4);

    // Counter wrap from all-ones.
    @(posedge clk);
    #1;
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    #1;
    chk("count_preload", bus.rx_count, 32'h0000FFFF);
    run_frame(32'h0F0F00FF, 1'b0);
    chk("count_wrap", bus.rx_count, 0);
    chk("data_wrap_frame", bus.rx_data, 32'h0F0F00FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
